// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared widths, control-bundle layout, stage-register types and forward-select codes.
// No logic or latency of its own.
// No flow control; imported by the hazard/forwarding pipe and its interface.
package ctrl_pipe_hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 2;
  localparam int CTRL_W     = 6 + ALUOP_W;
  localparam int EX_CTRL_W  = 1 + ALUOP_W + 1;

  // Bit positions inside the packed control bundle, MSB first.
  localparam int RW       = CTRL_W - 1;
  localparam int M2R      = CTRL_W - 2;
  localparam int MW       = CTRL_W - 3;
  localparam int MR       = CTRL_W - 4;
  localparam int ASRC     = CTRL_W - 5;
  localparam int ALUOP_HI = ALUOP_W;
  localparam int ALUOP_LO = 1;
  localparam int RDST     = 0;

  // Operand-source select encodings for the EX stage.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Same layout as the raw bundle, so a plain cast maps bits to fields.
  typedef struct packed {
    logic               rw;
    logic               m2r;
    logic               mw;
    logic               mr;
    logic               asrc;
    logic [ALUOP_W-1:0] aluop;
    logic               rdst;
  } ctrl_t;

  typedef struct packed {
    ctrl_t     ctrl;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd;
  } idex_t;

  typedef struct packed {
    logic      rw;
    logic      m2r;
    logic      mw;
    logic      mr;
    reg_addr_t dst;
  } exmem_t;

  typedef struct packed {
    logic      rw;
    logic      m2r;
    reg_addr_t dst;
  } memwb_t;

  // A destination only counts as a producer when it is not the hardwired zero register.
  function automatic logic reg_hit(input reg_addr_t dst, input reg_addr_t src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// Control bundle between the ID-stage controller (master) and the hazard pipe (slave).
// Purely wires; outputs of the slave are combinational from its stage registers.
// No handshake: the slave throttles fetch through pc_write_o / ifid_write_o.
interface ctrl_pipe_hazard_if;
  import ctrl_pipe_hazard_pkg::*;

  logic [CTRL_W-1:0]     id_ctrl_i;
  logic                  id_branch_i;
  logic                  branch_or_not_i;
  reg_addr_t             id_rs_i;
  reg_addr_t             id_rt_i;
  reg_addr_t             id_rd_i;

  logic                  pc_write_o;
  logic                  ifid_write_o;
  logic                  ifid_flush_o;
  logic [EX_CTRL_W-1:0]  ex_ctrl_o;
  logic [1:0]            mem_ctrl_o;
  logic [1:0]            wb_ctrl_o;
  reg_addr_t             wb_dst_o;
  logic [1:0]            fwd_a_o;
  logic [1:0]            fwd_b_o;
  logic                  fwd_id_a_o;
  logic                  fwd_id_b_o;

  modport master (
    output id_ctrl_i, id_branch_i, branch_or_not_i, id_rs_i, id_rt_i, id_rd_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, ex_ctrl_o, mem_ctrl_o,
           wb_ctrl_o, wb_dst_o, fwd_a_o, fwd_b_o, fwd_id_a_o, fwd_id_b_o
  );

  modport slave (
    input  id_ctrl_i, id_branch_i, branch_or_not_i, id_rs_i, id_rt_i, id_rd_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, ex_ctrl_o, mem_ctrl_o,
           wb_ctrl_o, wb_dst_o, fwd_a_o, fwd_b_o, fwd_id_a_o, fwd_id_b_o
  );

endinterface

// File: rtl/ctrl_pipe_hazard_hazard_fwd_unit.sv
// Stall, flush and forwarding-select decode for the 5-stage pipe with branch resolved in ID.
// Latency 0: purely combinational from stage-register contents and ID fields.
// Produces the stall that holds PC and IF/ID; accepts no backpressure itself.
module hazard_fwd_unit
  import ctrl_pipe_hazard_pkg::*;
(
  input  logic      id_branch,
  input  logic      branch_taken,
  input  reg_addr_t id_rs,
  input  reg_addr_t id_rt,
  input  logic      idex_rw,
  input  logic      idex_mr,
  input  reg_addr_t idex_rs,
  input  reg_addr_t idex_rt,
  input  reg_addr_t ex_dst,
  input  logic      exmem_rw,
  input  logic      exmem_mr,
  input  reg_addr_t exmem_dst,
  input  logic      memwb_rw,
  input  reg_addr_t memwb_dst,
  output logic      stall,
  output logic      flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic      fwd_id_a,
  output logic      fwd_id_b
);

  logic ex_hit_id;
  logic mem_hit_id;
  logic load_use;
  logic br_after_alu;
  logic br_after_load;

  assign ex_hit_id  = reg_hit(ex_dst, id_rs) || reg_hit(ex_dst, id_rt);
  assign mem_hit_id = reg_hit(exmem_dst, id_rs) || reg_hit(exmem_dst, id_rt);

  // The rt match is applied to every instruction, even ones that do not read rt.
  assign load_use      = idex_mr && ex_hit_id;
  assign br_after_alu  = id_branch && idex_rw && ex_hit_id;
  assign br_after_load = id_branch && exmem_mr && mem_hit_id;

  assign stall = load_use || br_after_alu || br_after_load;

  // A taken decision made on stale compare operands is discarded until the stall clears.
  assign flush = branch_taken && !stall;

  // EX operand selects: the younger producer in EX/MEM wins over MEM/WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (exmem_rw && reg_hit(exmem_dst, idex_rs)) begin
      fwd_a = FWD_MEM;
    end else if (memwb_rw && reg_hit(memwb_dst, idex_rs)) begin
      fwd_a = FWD_WB;
    end
    if (exmem_rw && reg_hit(exmem_dst, idex_rt)) begin
      fwd_b = FWD_MEM;
    end else if (memwb_rw && reg_hit(memwb_dst, idex_rt)) begin
      fwd_b = FWD_WB;
    end
  end

  // ID compare operands can only take an ALU result; load data is not ready yet.
  assign fwd_id_a = exmem_rw && !exmem_mr && reg_hit(exmem_dst, id_rs);
  assign fwd_id_b = exmem_rw && !exmem_mr && reg_hit(exmem_dst, id_rt);

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Carries ID control through ID/EX, EX/MEM, MEM/WB and drives stall/flush/forward selects.
// One cycle per stage; all outputs combinational from stage registers and ID inputs.
// On a hazard holds PC and IF/ID and inserts an all-zero bubble into ID/EX.
module ctrl_pipe_hazard
  import ctrl_pipe_hazard_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  ctrl_pipe_hazard_if.slave bus
);

  idex_t     idex;
  exmem_t    exmem;
  memwb_t    memwb;
  ctrl_t     id_ctrl;
  reg_addr_t ex_dst;
  logic      stall;
  logic      flush;

  assign id_ctrl = ctrl_t'(bus.id_ctrl_i);
  assign ex_dst  = idex.ctrl.rdst ? idex.rd : idex.rt;

  hazard_fwd_unit u_hazard_fwd (
    .id_branch    (bus.id_branch_i),
    .branch_taken (bus.branch_or_not_i),
    .id_rs        (bus.id_rs_i),
    .id_rt        (bus.id_rt_i),
    .idex_rw      (idex.ctrl.rw),
    .idex_mr      (idex.ctrl.mr),
    .idex_rs      (idex.rs),
    .idex_rt      (idex.rt),
    .ex_dst       (ex_dst),
    .exmem_rw     (exmem.rw),
    .exmem_mr     (exmem.mr),
    .exmem_dst    (exmem.dst),
    .memwb_rw     (memwb.rw),
    .memwb_dst    (memwb.dst),
    .stall        (stall),
    .flush        (flush),
    .fwd_a        (bus.fwd_a_o),
    .fwd_b        (bus.fwd_b_o),
    .fwd_id_a     (bus.fwd_id_a_o),
    .fwd_id_b     (bus.fwd_id_b_o)
  );

  // Advance the three stage registers every cycle; a stall replaces the ID/EX load with a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      if (stall) begin
        idex <= '0;
      end else begin
        idex.ctrl <= id_ctrl;
        idex.rs   <= bus.id_rs_i;
        idex.rt   <= bus.id_rt_i;
        idex.rd   <= bus.id_rd_i;
      end
      exmem.rw  <= idex.ctrl.rw;
      exmem.m2r <= idex.ctrl.m2r;
      exmem.mw  <= idex.ctrl.mw;
      exmem.mr  <= idex.ctrl.mr;
      exmem.dst <= ex_dst;
      memwb.rw  <= exmem.rw;
      memwb.m2r <= exmem.m2r;
      memwb.dst <= exmem.dst;
    end
  end

  // Reset holds fetch and keeps IF/ID cleared regardless of hazard state.
  assign bus.pc_write_o   = !rst_i && !stall;
  assign bus.ifid_write_o = !rst_i && !stall;
  assign bus.ifid_flush_o = rst_i || flush;

  assign bus.ex_ctrl_o  = {idex.ctrl.asrc, idex.ctrl.aluop, idex.ctrl.rdst};
  assign bus.mem_ctrl_o = {exmem.mw, exmem.mr};
  assign bus.wb_ctrl_o  = {memwb.rw, memwb.m2r};
  assign bus.wb_dst_o   = memwb.dst;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed-vector bench: each driven cycle pushes its hand-computed expectation into a queue,
// and a monitor on the falling edge pops and compares every cared-about output field.
// Fields marked DC are not compared for that cycle.
module tb_ctrl_pipe_hazard;
  import ctrl_pipe_hazard_pkg::*;

  localparam int DC = -1;
  localparam logic [7:0] NOP = 8'h00;
  localparam logic [7:0] LW  = 8'h98;
  localparam logic [7:0] ADD = 8'h85;
  localparam logic [7:0] BEQ = 8'h02;

  typedef struct {
    string nm;
    int pcw, ifw, fl, exc, memc, wbc, wbd, fa, fb, fia, fib;
  } exp_t;

  logic clk;
  logic rst;
  int checks;
  int failures;
  exp_t q[$];

  ctrl_pipe_hazard_if bus();

  ctrl_pipe_hazard dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    if (req != DC) begin
      checks++;
      if (act != req) begin
        failures++;
        $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
      end
    end
  endtask

  // Monitor: outputs are settled half a cycle after the driver updated inputs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "pc_write",   int'(bus.pc_write_o),   e.pcw);
      chk(e.nm, "ifid_write", int'(bus.ifid_write_o), e.ifw);
      chk(e.nm, "ifid_flush", int'(bus.ifid_flush_o), e.fl);
      chk(e.nm, "ex_ctrl",    int'(bus.ex_ctrl_o),    e.exc);
      chk(e.nm, "mem_ctrl",   int'(bus.mem_ctrl_o),   e.memc);
      chk(e.nm, "wb_ctrl",    int'(bus.wb_ctrl_o),    e.wbc);
      chk(e.nm, "wb_dst",     int'(bus.wb_dst_o),     e.wbd);
      chk(e.nm, "fwd_a",      int'(bus.fwd_a_o),      e.fa);
      chk(e.nm, "fwd_b",      int'(bus.fwd_b_o),      e.fb);
      chk(e.nm, "fwd_id_a",   int'(bus.fwd_id_a_o),   e.fia);
      chk(e.nm, "fwd_id_b",   int'(bus.fwd_id_b_o),   e.fib);
    end
  end

  task automatic step(input string nm, input logic r, input logic [7:0] c,
                      input logic br, input logic tk,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input int pcw, input int ifw, input int fl, input int exc,
                      input int memc, input int wbc, input int wbd,
                      input int fa, input int fb, input int fia, input int fib);
    exp_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.id_ctrl_i       = c;
    bus.id_branch_i     = br;
    bus.branch_or_not_i = tk;
    bus.id_rs_i         = rs;
    bus.id_rt_i         = rt;
    bus.id_rd_i         = rd;
    e.nm = nm; e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.exc = exc; e.memc = memc;
    e.wbc = wbc; e.wbd = wbd; e.fa = fa; e.fb = fb; e.fia = fia; e.fib = fib;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++)
      step("drain", 0, NOP, 0, 0, 0, 0, 0, 1, 1, 0, DC, DC, DC, DC, DC, DC, DC, DC);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst                 = 1'b1;
    bus.id_ctrl_i       = 8'hFF;
    bus.id_branch_i     = 1'b0;
    bus.branch_or_not_i = 1'b0;
    bus.id_rs_i         = 5'd1;
    bus.id_rt_i         = 5'd2;
    bus.id_rd_i         = 5'd3;

    //    name       rst ctrl  br tk rs  rt  rd   pcw ifw fl exc mem wb wbd fa fb fia fib
    step("rst0",     1, 8'hFF, 0, 0, 1,  2,  3,   0,  0,  1, 0,  0,  0, 0,  0, 0, 0,  0);
    step("rst1",     1, 8'hFF, 0, 0, 1,  2,  3,   0,  0,  1, 0,  0,  0, 0,  0, 0, 0,  0);
    step("rel",      0, NOP,   0, 0, 0,  0,  0,   1,  1,  0, 0,  0,  0, 0,  0, 0, 0,  0);

    // Load followed by a dependent ALU op: one bubble, then MEM/WB forward.
    step("lu_lw",    0, LW,    0, 0, 2,  8,  0,   1,  1,  0, 0,  0,  0, 0,  0, 0, 0,  0);
    step("lu_stall", 0, ADD,   0, 0, 8,  3,  11,  0,  0,  0, 8,  0,  0, 0,  0, 0, 0,  0);
    step("lu_bubble",0, ADD,   0, 0, 8,  3,  11,  1,  1,  0, 0,  1,  0, 0,  0, 0, 0,  0);
    step("lu_fwd",   0, NOP,   0, 0, 0,  0,  0,   1,  1,  0, 5,  0,  2, 8,  1, 0, 0,  0);
    drain();

    // ALU op followed by a dependent taken branch: one stall, then single-cycle flush.
    step("ba_add",   0, ADD,   0, 0, 1,  2,  9,   1,  1,  0, 0,  0,  0, 0,  0, 0, 0,  0);
    step("ba_stall", 0, BEQ,   1, 1, 9,  4,  0,   0,  0,  0, 5,  0,  0, 0,  0, 0, 0,  0);
    step("ba_flush", 0, BEQ,   1, 1, 9,  4,  0,   1,  1,  1, 0,  0,  0, 0,  0, 0, 1,  0);
    step("ba_after", 0, NOP,   0, 0, 0,  0,  0,   1,  1,  0, 2,  0,  2, 9,  1, 0, 0,  0);
    drain();

    // Load followed by a dependent taken branch: two stalls, no flush until released.
    step("bl_lw",    0, LW,    0, 0, 1,  10, 0,   1,  1,  0, 0,  0,  0, 0,  0, 0, 0,  0);
    step("bl_st1",   0, BEQ,   1, 1, 10, 3,  0,   0,  0,  0, 8,  0,  0, 0,  0, 0, 0,  0);
    step("bl_st2",   0, BEQ,   1, 1, 10, 3,  0,   0,  0,  0, 0,  1,  0, 0,  0, 0, 0,  0);
    step("bl_flush", 0, BEQ,   1, 1, 10, 3,  0,   1,  1,  1, 0,  0,  2, 10, 0, 0, 0,  0);
    step("bl_after", 0, NOP,   0, 0, 0,  0,  0,   1,  1,  0, 2,  0,  0, 0,  0, 0, 0,  0);
    drain();

    // Two producers of the same register: EX/MEM wins over MEM/WB.
    step("fp_a1",    0, ADD,   0, 0, 1,  2,  5,   1,  1,  0, 0,  0,  0, 0,  0, 0, 0,  0);
    step("fp_a2",    0, ADD,   0, 0, 3,  4,  5,   1,  1,  0, 5,  0,  0, 0,  0, 0, 0,  0);
    step("fp_a3",    0, ADD,   0, 0, 5,  5,  6,   1,  1,  0, 5,  0,  0, 0,  0, 0, 1,  1);
    step("fp_use",   0, NOP,   0, 0, 0,  0,  0,   1,  1,  0, 5,  0,  2, 5,  2, 2, 0,  0);
    drain();

    // Register 0 is never a producer, for forwarding or for load-use.
    step("z_a1",     0, ADD,   0, 0, 1,  2,  0,   1,  1,  0, 0,  0,  0, 0,  0, 0, 0,  0);
    step("z_a2",     0, ADD,   0, 0, 3,  4,  0,   1,  1,  0, 5,  0,  0, 0,  0, 0, 0,  0);
    step("z_a3",     0, ADD,   0, 0, 0,  0,  6,   1,  1,  0, 5,  0,  0, 0,  0, 0, 0,  0);
    step("z_use",    0, NOP,   0, 0, 0,  0,  0,   1,  1,  0, 5,  0,  2, 0,  0, 0, 0,  0);
    drain();
    step("z_lw",     0, LW,    0, 0, 1,  0,  0,   1,  1,  0, 0,  0,  0, 0,  0, 0, 0,  0);
    step("z_lu",     0, ADD,   0, 0, 0,  0,  7,   1,  1,  0, 8,  0,  0, 0,  0, 0, 0,  0);
    drain();

    // Reset on the first stall cycle of a load/branch pair empties the pipe.
    step("rs_lw",    0, LW,    0, 0, 1,  10, 0,   1,  1,  0, 0,  0,  0, 0,  0, 0, 0,  0);
    step("rs_rst",   1, BEQ,   1, 1, 10, 3,  0,   0,  0,  1, 8,  0,  0, 0,  DC,DC,0,  0);
    step("rs_rel",   0, NOP,   0, 0, 0,  0,  0,   1,  1,  0, 0,  0,  0, 0,  0, 0, 0,  0);
    step("rs_run",   0, NOP,   0, 0, 0,  0,  0,   1,  1,  0, 0,  0,  0, 0,  0, 0, 0,  0);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
